// File: rtl/avl_test_pkg.sv
// Shared types for the Avalon-MM test driver: FSM states, command opcodes and the queued command record.
package avl_test_pkg;

  // Widest address/data a command record can carry; instances use the low ADDR_W/DATA_W bits.
  localparam int CMD_ADDR_MAX = 32;
  localparam int CMD_DATA_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_WRITE      = 1'b0,
    OP_READ_CHECK = 1'b1
  } op_t;

  typedef struct packed {
    op_t                     op;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] data;
    logic [CMD_DATA_MAX-1:0] mask;
  } cmd_t;

  // High when any bit selected by mask differs between observed and expected data.
  function automatic logic masked_miss(input logic [CMD_DATA_MAX-1:0] got,
                                       input logic [CMD_DATA_MAX-1:0] exp,
                                       input logic [CMD_DATA_MAX-1:0] mask);
    return |((got ^ exp) & mask);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO; pointers carry one extra wrap bit to tell full from empty.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/avl_test_driver.sv
// Queues WRITE / READ_CHECK commands, then replays them on an Avalon-MM master port,
// tallying masked read-compare results and aborting a run on a waitrequest stall timeout.
module avl_test_driver
  import avl_test_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_op,
  input  logic [ADDR_W-1:0]          i_cmd_addr,
  input  logic [DATA_W-1:0]          i_cmd_data,
  input  logic [DATA_W-1:0]          i_cmd_mask,
  input  logic                       i_start,
  output logic [ADDR_W-1:0]          o_avm_address,
  output logic                       o_avm_read,
  output logic                       o_avm_write,
  output logic [DATA_W-1:0]          o_avm_writedata,
  input  logic [DATA_W-1:0]          i_avm_readdata,
  input  logic                       i_avm_waitrequest,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(DEPTH):0]     o_pass_cnt,
  output logic [$clog2(DEPTH):0]     o_fail_cnt,
  output logic [$clog2(DEPTH)-1:0]   o_first_fail,
  output logic                       o_timeout
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int FIFO_W  = 1 + ADDR_W + 2 * DATA_W;

  state_t              state;
  state_t              state_nxt;
  cmd_t                cmd_p0;
  logic [FIFO_W-1:0]   fifo_wr;
  logic [FIFO_W-1:0]   fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                flush;
  logic                run_start;
  logic                acc_timeout;
  logic                miss;
  logic [STALL_W-1:0]  stall_cnt;
  logic [IDX_W-1:0]    idx_p0;

  assign push        = i_cmd_valid && o_cmd_ready;
  assign fifo_wr     = {i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_mask};
  assign acc_timeout = i_avm_waitrequest && (stall_cnt == STALL_W'(TIMEOUT - 1));
  assign miss        = masked_miss(CMD_DATA_MAX'(i_avm_readdata), cmd_p0.data, cmd_p0.mask);

  cmd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Strobes decode straight from the state register so reset drops them without waiting for a clock.
  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_avm_read  = 1'b0;
    o_avm_write = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    run_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        o_cmd_ready = !fifo_full;
        if (i_start) begin
          run_start = 1'b1;
          state_nxt = fifo_empty ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_busy    = 1'b1;
        pop       = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_busy      = 1'b1;
        o_avm_read  = (cmd_p0.op == OP_READ_CHECK);
        o_avm_write = (cmd_p0.op == OP_WRITE);
        if (!i_avm_waitrequest) begin
          state_nxt = fifo_empty ? ST_DONE : ST_FETCH;
        end else if (acc_timeout) begin
          flush     = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: command register loaded on pop; results accumulate on the completing ACCESS cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cmd_p0       <= '0;
      stall_cnt    <= '0;
      idx_p0       <= '0;
      o_pass_cnt   <= '0;
      o_fail_cnt   <= '0;
      o_first_fail <= '0;
      o_timeout    <= 1'b0;
    end else begin
      if (run_start) begin
        idx_p0       <= '0;
        o_pass_cnt   <= '0;
        o_fail_cnt   <= '0;
        o_first_fail <= '0;
        o_timeout    <= 1'b0;
      end
      if (pop) begin
        cmd_p0.op   <= op_t'(fifo_rd[FIFO_W-1]);
        cmd_p0.addr <= CMD_ADDR_MAX'(fifo_rd[FIFO_W-2 -: ADDR_W]);
        cmd_p0.data <= CMD_DATA_MAX'(fifo_rd[2*DATA_W-1 -: DATA_W]);
        cmd_p0.mask <= CMD_DATA_MAX'(fifo_rd[DATA_W-1:0]);
        stall_cnt   <= '0;
      end
      if (state == ST_ACCESS) begin
        if (!i_avm_waitrequest) begin
          idx_p0 <= idx_p0 + 1'b1;
          if (cmd_p0.op == OP_READ_CHECK) begin
            if (miss) begin
              o_fail_cnt <= o_fail_cnt + 1'b1;
              if (o_fail_cnt == '0)
                o_first_fail <= idx_p0;
            end else begin
              o_pass_cnt <= o_pass_cnt + 1'b1;
            end
          end
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
          if (acc_timeout)
            o_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_avm_address   = cmd_p0.addr[ADDR_W-1:0];
  assign o_avm_writedata = cmd_p0.data[DATA_W-1:0];

endmodule

// File: tb/tb_avl_test_driver.sv
// Randomized bench for avl_test_driver: a sequential reference model predicts each run's accesses and results.
module tb_avl_test_driver;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic              i_clk;
  logic              i_reset;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_op;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_data;
  logic [DATA_W-1:0] i_cmd_mask;
  logic              i_start;
  logic [ADDR_W-1:0] o_avm_address;
  logic              o_avm_read;
  logic              o_avm_write;
  logic [DATA_W-1:0] o_avm_writedata;
  logic [DATA_W-1:0] i_avm_readdata;
  logic              i_avm_waitrequest;
  logic              o_busy;
  logic              o_done;
  logic [2:0]        o_pass_cnt;
  logic [2:0]        o_fail_cnt;
  logic [1:0]        o_first_fail;
  logic              o_timeout;

  avl_test_driver #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_cmd_op          (i_cmd_op),
    .i_cmd_addr        (i_cmd_addr),
    .i_cmd_data        (i_cmd_data),
    .i_cmd_mask        (i_cmd_mask),
    .i_start           (i_start),
    .o_avm_address     (o_avm_address),
    .o_avm_read        (o_avm_read),
    .o_avm_write       (o_avm_write),
    .o_avm_writedata   (o_avm_writedata),
    .i_avm_readdata    (i_avm_readdata),
    .i_avm_waitrequest (i_avm_waitrequest),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_pass_cnt        (o_pass_cnt),
    .o_fail_cnt        (o_fail_cnt),
    .o_first_fail      (o_first_fail),
    .o_timeout         (o_timeout)
  );

  typedef struct {
    bit          op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
  } tcmd_t;

  tcmd_t       q_cmd[$];
  logic [31:0] model_mem [8];
  logic [31:0] slave_mem [8];
  logic [63:0] obs_q[$];
  int          total = 0;
  int          bad = 0;
  int          strobe_cycles = 0;
  int          both_err = 0;
  int          stable_err = 0;
  int          ws_mode = 3;
  int          hold_left = 0;
  bit          prev_active = 0;
  bit          prev_wait = 0;
  logic [36:0] prev_bus = '0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign i_avm_readdata = slave_mem[o_avm_address];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave stall generator: 0=random short stalls, 1=hold for hold_left cycles, 2=stuck, 3=never.
  initial begin
    int consec = 0;
    i_avm_waitrequest = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (ws_mode)
        0: begin
          if ((o_avm_read || o_avm_write) && consec < 3 && $urandom_range(0, 1) == 1) begin
            i_avm_waitrequest = 1'b1;
            consec++;
          end else begin
            i_avm_waitrequest = 1'b0;
            consec = 0;
          end
        end
        1: begin
          if ((o_avm_read || o_avm_write) && hold_left > 0) begin
            i_avm_waitrequest = 1'b1;
            hold_left--;
          end else begin
            i_avm_waitrequest = 1'b0;
          end
        end
        2: i_avm_waitrequest = 1'b1;
        default: i_avm_waitrequest = 1'b0;
      endcase
    end
  end

  // Bus monitor and slave write port.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_avm_read && o_avm_write)
        both_err++;
      if (o_avm_read || o_avm_write) begin
        strobe_cycles++;
        if (prev_active && prev_wait &&
            ({o_avm_read, o_avm_write, o_avm_address, o_avm_writedata} != prev_bus))
          stable_err++;
        if (!i_avm_waitrequest) begin
          obs_q.push_back({28'd0, o_avm_write, o_avm_address,
                           o_avm_write ? o_avm_writedata : i_avm_readdata});
          if (o_avm_write)
            slave_mem[o_avm_address] = o_avm_writedata;
        end
      end
      prev_active = o_avm_read || o_avm_write;
      prev_wait   = i_avm_waitrequest;
      prev_bus    = {o_avm_read, o_avm_write, o_avm_address, o_avm_writedata};
    end
  end

  task automatic push(input bit op, input logic [2:0] a, input logic [31:0] d, input logic [31:0] m);
    tcmd_t c;
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_addr  = a;
    i_cmd_data  = d;
    i_cmd_mask  = m;
    chk("cmd_ready", o_cmd_ready, q_cmd.size() < DEPTH);
    if (q_cmd.size() < DEPTH) begin
      c.op = op; c.addr = a; c.data = d; c.mask = m;
      q_cmd.push_back(c);
    end
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  // Predict the run from the queued commands, start it, then compare results and the access trace.
  task automatic run_and_check(input string tag, input int exp_strb, input bit exp_to);
    logic [63:0] exp_acc[$];
    logic [31:0] got;
    int          ep = 0;
    int          ef = 0;
    int          ff = 0;
    bit          seen = 0;
    bit          nonempty;
    int          n;
    nonempty = (q_cmd.size() > 0);
    if (!exp_to) begin
      foreach (q_cmd[i]) begin
        if (!q_cmd[i].op) begin
          model_mem[q_cmd[i].addr] = q_cmd[i].data;
          exp_acc.push_back({28'd0, 1'b1, q_cmd[i].addr, q_cmd[i].data});
        end else begin
          got = model_mem[q_cmd[i].addr];
          exp_acc.push_back({28'd0, 1'b0, q_cmd[i].addr, got});
          if (((got ^ q_cmd[i].data) & q_cmd[i].mask) == 32'd0) begin
            ep++;
          end else begin
            if (ef == 0) ff = i;
            ef++;
          end
        end
      end
    end
    obs_q.delete();
    strobe_cycles = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      if (c == 0) begin
        i_start = 1'b0;
        chk({tag, "_busy"}, o_busy, nonempty);
      end
      if (o_done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    chk({tag, "_pass"}, o_pass_cnt, ep);
    chk({tag, "_fail"}, o_fail_cnt, ef);
    chk({tag, "_first_fail"}, o_first_fail, ff);
    chk({tag, "_timeout"}, o_timeout, exp_to);
    chk({tag, "_strobes_idle"}, {o_avm_read, o_avm_write}, 2'b00);
    chk({tag, "_busy_end"}, o_busy, 1'b0);
    chk({tag, "_n_acc"}, obs_q.size(), exp_acc.size());
    n = (obs_q.size() < exp_acc.size()) ? obs_q.size() : exp_acc.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_acc"}, obs_q[i], exp_acc[i]);
    if (exp_strb >= 0)
      chk({tag, "_strobe_cycles"}, strobe_cycles, exp_strb);
    @(negedge i_clk);
    chk({tag, "_done_pulse"}, o_done, 1'b0);
    q_cmd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] shadow [8];
    logic [31:0] v;
    logic [2:0]  a;
    bit          op;
    int          n;
    bit          strb_seen;

    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      model_mem[i] = v;
      slave_mem[i] = v;
    end
    i_reset = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_op = 1'b0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_mask = '0;
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", o_cmd_ready, 1'b1);
    chk("rst_strobes", {o_avm_read, o_avm_write}, 2'b00);
    chk("rst_busy_done", {o_busy, o_done, o_timeout}, 3'b000);
    chk("rst_counts", {o_pass_cnt, o_fail_cnt, o_first_fail}, 8'd0);
    chk("rst_bus", {o_avm_address, o_avm_writedata}, 35'd0);
    i_reset = 1'b0;

    // Basic write then matching read-back.
    ws_mode = 3;
    push(1'b0, 3'd2, 32'h1, 32'hFFFF_FFFF);
    push(1'b1, 3'd2, 32'h1, 32'hFFFF_FFFF);
    run_and_check("wr_rd", 2, 1'b0);

    // Masked compare: only the low nibble is checked first, then only the high nibble.
    model_mem[5] = 32'hAF;
    slave_mem[5] = 32'hAF;
    push(1'b1, 3'd5, 32'hFF, 32'h0F);
    run_and_check("mask_lo", 1, 1'b0);
    push(1'b1, 3'd5, 32'hFF, 32'hF0);
    run_and_check("mask_hi", 1, 1'b0);

    // Five stall cycles on one write.
    ws_mode = 1;
    hold_left = 5;
    push(1'b0, 3'd6, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    run_and_check("hold5", 6, 1'b0);
    ws_mode = 3;

    // Fill the FIFO, try one more, replay in order.
    push(1'b0, 3'd0, $urandom, 32'hFFFF_FFFF);
    push(1'b0, 3'd1, $urandom, 32'hFFFF_FFFF);
    push(1'b1, 3'd0, $urandom, 32'hFFFF_FFFF);
    push(1'b1, 3'd1, $urandom, 32'h0000_00FF);
    push(1'b0, 3'd3, $urandom, 32'hFFFF_FFFF);
    run_and_check("full", DEPTH, 1'b0);

    // Randomized runs with short random stalls.
    ws_mode = 0;
    repeat (8) begin
      for (int i = 0; i < 8; i++) shadow[i] = model_mem[i];
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        op = $urandom_range(0, 1);
        a  = 3'($urandom_range(0, 7));
        if (!op) begin
          v = $urandom;
          shadow[a] = v;
          push(1'b0, a, v, 32'hFFFF_FFFF);
        end else begin
          v = ($urandom_range(0, 1) == 1) ? shadow[a] : (shadow[a] ^ (32'h1 << $urandom_range(0, 31)));
          push(1'b1, a, v, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom));
        end
      end
      run_and_check("rnd", -1, 1'b0);
    end

    // Stuck waitrequest with three queued commands.
    ws_mode = 2;
    push(1'b0, 3'd4, 32'h1234, 32'hFFFF_FFFF);
    push(1'b1, 3'd4, 32'h1234, 32'hFFFF_FFFF);
    push(1'b0, 3'd7, 32'h5678, 32'hFFFF_FFFF);
    run_and_check("tmo", TIMEOUT, 1'b1);
    ws_mode = 3;
    repeat (2) @(negedge i_clk);
    chk("tmo_held", o_timeout, 1'b1);
    run_and_check("tmo_flushed", 0, 1'b0);

    // Reset in the middle of a stalled access.
    ws_mode = 2;
    push(1'b0, 3'd1, 32'hAAAA, 32'hFFFF_FFFF);
    push(1'b0, 3'd2, 32'hBBBB, 32'hFFFF_FFFF);
    push(1'b0, 3'd3, 32'hCCCC, 32'hFFFF_FFFF);
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    strb_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_avm_read || o_avm_write) begin
        strb_seen = 1;
        break;
      end
      @(negedge i_clk);
    end
    chk("mid_strobe_seen", strb_seen, 1'b1);
    #2 i_reset = 1'b1;
    #1;
    chk("mid_rst_strobes", {o_avm_read, o_avm_write}, 2'b00);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_bus", {o_avm_address, o_avm_writedata}, 35'd0);
    q_cmd.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
    ws_mode = 3;
    @(negedge i_clk);
    chk("mid_rst_ready", o_cmd_ready, 1'b1);
    run_and_check("mid_rst_empty", 0, 1'b0);

    chk("both_strobes", both_err, 0);
    chk("bus_stable", stable_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
